// File: rtl/axixl_pkg.sv
// Shared types and helpers for the axixl AXI4-Lite traffic generator/checker.
// Holds the sequencer state encoding, AXI response codes and the data pattern.
// No logic of its own; imported by the sequencer and its sub-blocks.
package axixl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // SLVERR and DECERR are failures; OKAY and EXOKAY are both accepted.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

    // Pattern written to (and expected back from) register number idx.
    function automatic logic [63:0] exp_data(input logic [7:0] idx);
        return {56'd0, idx} + 64'd1;
    endfunction

endpackage

// File: rtl/axixl_init_pulse.sv
// Start detector: registers INIT twice and emits a one-cycle pulse on its rising edge.
// Latency: pulse is high in the cycle after INIT is first sampled high.
// Backpressure: none; a held-high INIT yields exactly one pulse.
// Ports: clk/rst_n (async active-low), i_init (raw request), o_start (one-cycle pulse).
module axixl_init_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic i_init,
    output logic o_start
);

    logic r_q1;
    logic r_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q1 <= 1'b0;
            r_q2 <= 1'b0;
        end else begin
            r_q1 <= i_init;
            r_q2 <= r_q1;
        end
    end

    assign o_start = r_q1 & ~r_q2;

endmodule

// File: rtl/axixl_lite_txn_master.sv
// AXI4-Lite master: on an INIT rising edge writes N registers with index+1, then reads and compares them.
// Latency: first AWVALID 3 cycles after INIT rises; one transaction outstanding at a time.
// Backpressure: every VALID (and its ADDR/DATA) is held until READY; B/R accepted only when awaited.
// Ports: ACLK/ARESETN, INIT_AXI_TXN in, TXN_DONE/ERROR sticky status out, M_AXI_* AXI4-Lite master.
module axixl_lite_txn_master
    import axixl_pkg::*;
#(
    parameter     C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
    parameter int C_M_AXI_ADDR_WIDTH         = 32,
    parameter int C_M_AXI_DATA_WIDTH         = 32,
    parameter int C_M_TRANSACTIONS_NUM       = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic                              INIT_AXI_TXN,
    output logic                              TXN_DONE,
    output logic                              ERROR,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam logic [AW-1:0] BASE   = AW'(C_M_TARGET_SLAVE_BASE_ADDR);
    localparam logic [7:0]    N_LAST = 8'(C_M_TRANSACTIONS_NUM - 1);

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_index;
    logic            r_busy;      // a transaction is in flight
    logic            r_aw_done;
    logic            r_w_done;
    logic            r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic            r_txn_done, r_error;
    logic [AW-1:0]   r_awaddr, r_araddr;
    logic [DW-1:0]   r_wdata;

    logic            w_start;
    logic            w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic            w_last;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_exp;

    axixl_init_pulse u_init_pulse (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .i_init  (INIT_AXI_TXN),
        .o_start (w_start)
    );

    assign w_aw_hs = r_awvalid & M_AXI_AWREADY;
    assign w_w_hs  = r_wvalid  & M_AXI_WREADY;
    assign w_b_hs  = r_bready  & M_AXI_BVALID;
    assign w_ar_hs = r_arvalid & M_AXI_ARREADY;
    assign w_r_hs  = r_rready  & M_AXI_RVALID;
    assign w_last  = (r_index == N_LAST);
    // Word-aligned register address; the sum wraps naturally at AW bits.
    assign w_addr  = BASE + AW'({r_index, 2'b00});
    assign w_exp   = DW'(exp_data(r_index));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start)          w_next = WRITE;
            WRITE:   if (w_b_hs && w_last) w_next = READ;
            READ:    if (w_r_hs && w_last) w_next = DONE;
            DONE:                          w_next = IDLE;
            default:                       w_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_index    <= '0;
            r_busy     <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
            r_txn_done <= 1'b0;
            r_error    <= 1'b0;
            r_awaddr   <= '0;
            r_araddr   <= '0;
            r_wdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_txn_done <= 1'b0;
                        r_error    <= 1'b0;
                        r_index    <= '0;
                    end
                end
                WRITE: begin
                    if (!r_busy) begin
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_awaddr  <= w_addr;
                        r_wdata   <= w_exp;
                        r_busy    <= 1'b1;
                    end
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    // Open BREADY as soon as the later of AW/W completes, including
                    // the cycle of that handshake itself.
                    if (r_busy && !r_bready && (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                        r_bready <= 1'b1;
                    end
                    if (w_b_hs) begin
                        r_bready  <= 1'b0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_error   <= r_error | resp_is_err(M_AXI_BRESP);
                        r_index   <= w_last ? 8'd0 : r_index + 8'd1;
                    end
                end
                READ: begin
                    if (!r_busy) begin
                        r_arvalid <= 1'b1;
                        r_araddr  <= w_addr;
                        r_busy    <= 1'b1;
                    end
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                    if (w_r_hs) begin
                        r_rready <= 1'b0;
                        r_busy   <= 1'b0;
                        r_error  <= r_error | resp_is_err(M_AXI_RRESP) | (M_AXI_RDATA != w_exp);
                        r_index  <= w_last ? 8'd0 : r_index + 8'd1;
                        // Raised on entry to DONE so it is already visible in that state.
                        if (w_last) r_txn_done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign TXN_DONE      = r_txn_done;
    assign ERROR         = r_error;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axixl_lite_txn_master.sv
// Bench for axixl_lite_txn_master: AXI4-Lite slave model with configurable ready/response
// delays and error injection, table-driven and randomized runs, plus hand-written
// sequences for start latency, held/repeated INIT and reset in mid-transaction.
module tb_axixl_lite_txn_master;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        INIT_AXI_TXN = 1'b0;
    logic        TXN_DONE, ERROR;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;

    always #5 ACLK = ~ACLK;

    axixl_lite_txn_master #(
        .C_M_TARGET_SLAVE_BASE_ADDR (32'h4000_0000),
        .C_M_AXI_ADDR_WIDTH         (32),
        .C_M_AXI_DATA_WIDTH         (32),
        .C_M_TRANSACTIONS_NUM       (N)
    ) dut (
        .ACLK (ACLK), .ARESETN (ARESETN), .INIT_AXI_TXN (INIT_AXI_TXN),
        .TXN_DONE (TXN_DONE), .ERROR (ERROR),
        .M_AXI_AWADDR (M_AXI_AWADDR), .M_AXI_AWPROT (M_AXI_AWPROT),
        .M_AXI_AWVALID (M_AXI_AWVALID), .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA (M_AXI_WDATA), .M_AXI_WSTRB (M_AXI_WSTRB),
        .M_AXI_WVALID (M_AXI_WVALID), .M_AXI_WREADY (M_AXI_WREADY),
        .M_AXI_BRESP (M_AXI_BRESP), .M_AXI_BVALID (M_AXI_BVALID), .M_AXI_BREADY (M_AXI_BREADY),
        .M_AXI_ARADDR (M_AXI_ARADDR), .M_AXI_ARPROT (M_AXI_ARPROT),
        .M_AXI_ARVALID (M_AXI_ARVALID), .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA (M_AXI_RDATA), .M_AXI_RRESP (M_AXI_RRESP),
        .M_AXI_RVALID (M_AXI_RVALID), .M_AXI_RREADY (M_AXI_RREADY)
    );

    // One scenario: slave delays, injected faults and the hand-derived ERROR outcome.
    typedef struct {
        int         aw, w, b, ar, r;
        int         bad_b;   // B index answered with bresp (-1: none)
        logic [1:0] bresp;
        int         bad_r;   // R index answered with rresp (-1: none)
        logic [1:0] rresp;
        int         dead;    // R index returning 0xDEAD (-1: none)
        logic       exp_err;
    } vec_t;

    vec_t tbl[7];
    vec_t rv;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave configuration (written by the main sequence only).
    int         c_aw, c_w, c_b, c_ar, c_r, c_bad_b, c_bad_r, c_dead;
    logic [1:0] c_bresp, c_rresp;
    int         clr_req = 0;

    // Slave observations (written by the slave process only).
    logic [31:0] q_wa[$];
    logic [31:0] q_wd[$];
    logic [31:0] q_ra[$];
    logic [31:0] mem[logic [31:0]];
    int          rd_cnt, nb, viol, vld_seen;
    logic        err_before, err_after;

    bit seen;

    // ---------------- slave model ----------------
    initial begin : slave
        int          clr_seen, aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        logic        aw_got, w_got, ar_got, s_aw, s_w, s_b, s_ar, s_r, v_aw, v_w, v_ar;
        logic        pend_aw, pend_w, pend_ar, err_s;
        logic [31:0] sa_aw, sd_w, sa_ar, prev_aw, prev_wd, prev_ar, last_wa, last_wd, cur_ra;
        clr_seen = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; ar_got = 0; pend_aw = 0; pend_w = 0; pend_ar = 0;
        prev_aw = 0; prev_wd = 0; prev_ar = 0; last_wa = 0; last_wd = 0; cur_ra = 0;
        rd_cnt = 0; nb = 0; viol = 0; vld_seen = 0; err_before = 0; err_after = 0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
        M_AXI_BVALID = 0; M_AXI_BRESP = 0; M_AXI_RVALID = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
        forever begin
            @(negedge ACLK);
            v_aw = M_AXI_AWVALID; v_w = M_AXI_WVALID; v_ar = M_AXI_ARVALID;
            s_aw = v_aw && M_AXI_AWREADY;
            s_w  = v_w && M_AXI_WREADY;
            s_b  = M_AXI_BVALID && M_AXI_BREADY;
            s_ar = v_ar && M_AXI_ARREADY;
            s_r  = M_AXI_RVALID && M_AXI_RREADY;
            sa_aw = M_AXI_AWADDR; sd_w = M_AXI_WDATA; sa_ar = M_AXI_ARADDR; err_s = ERROR;
            if (v_aw || v_w || v_ar) vld_seen++;
            // AXI stability, BREADY/RREADY gating, single outstanding, no write/read overlap.
            if (pend_aw && (!v_aw || sa_aw != prev_aw)) viol++;
            if (pend_w && (!v_w || sd_w != prev_wd)) viol++;
            if (pend_ar && (!v_ar || sa_ar != prev_ar)) viol++;
            if (M_AXI_BREADY && !(aw_got && w_got)) viol++;
            if (M_AXI_RREADY && !ar_got) viol++;
            if ((s_aw && aw_got) || (s_w && w_got) || (s_ar && ar_got)) viol++;
            if ((v_aw || v_w || M_AXI_BREADY) && (v_ar || M_AXI_RREADY)) viol++;
            @(posedge ACLK);
            #1;
            if (clr_req != clr_seen) begin
                clr_seen = clr_req;
                q_wa.delete(); q_wd.delete(); q_ra.delete();
                rd_cnt = 0; nb = 0; viol = 0; vld_seen = 0; err_before = 0; err_after = 0;
                aw_got = 0; w_got = 0; ar_got = 0; pend_aw = 0; pend_w = 0; pend_ar = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                M_AXI_BVALID = 0; M_AXI_RVALID = 0;
            end else begin
                if (s_b) begin
                    mem[last_wa] = last_wd;
                    M_AXI_BVALID = 0; aw_got = 0; w_got = 0; b_cnt = 0; nb++;
                end
                if (s_aw) begin q_wa.push_back(sa_aw); last_wa = sa_aw; aw_got = 1; end
                if (s_w)  begin q_wd.push_back(sd_w);  last_wd = sd_w;  w_got  = 1; end
                if (s_r) begin
                    M_AXI_RVALID = 0; ar_got = 0; r_cnt = 0;
                    if (rd_cnt == c_dead) begin err_before = err_s; err_after = ERROR; end
                    rd_cnt++;
                end
                if (s_ar) begin q_ra.push_back(sa_ar); cur_ra = sa_ar; ar_got = 1; end
                aw_cnt = (s_aw || !v_aw) ? 0 : aw_cnt + 1;
                w_cnt  = (s_w  || !v_w)  ? 0 : w_cnt + 1;
                ar_cnt = (s_ar || !v_ar) ? 0 : ar_cnt + 1;
                pend_aw = v_aw && !s_aw; prev_aw = sa_aw;
                pend_w  = v_w  && !s_w;  prev_wd = sd_w;
                pend_ar = v_ar && !s_ar; prev_ar = sa_ar;
                if (aw_got && w_got && !M_AXI_BVALID) begin
                    if (b_cnt >= c_b) begin
                        M_AXI_BVALID = 1;
                        M_AXI_BRESP  = (nb == c_bad_b) ? c_bresp : 2'b00;
                    end else b_cnt++;
                end
                if (ar_got && !M_AXI_RVALID) begin
                    if (r_cnt >= c_r) begin
                        M_AXI_RVALID = 1;
                        M_AXI_RDATA  = (rd_cnt == c_dead) ? 32'hDEAD :
                                       (mem.exists(cur_ra) ? mem[cur_ra] : 32'h0);
                        M_AXI_RRESP  = (rd_cnt == c_bad_r) ? c_rresp : 2'b00;
                    end else r_cnt++;
                end
            end
            M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= c_aw);
            M_AXI_WREADY  = M_AXI_WVALID  && (w_cnt  >= c_w);
            M_AXI_ARREADY = M_AXI_ARVALID && (ar_cnt >= c_ar);
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference outcome: any SLVERR/DECERR response or any wrong read data within the N transfers.
    function automatic logic model_err(input vec_t v);
        return (v.bad_b >= 0 && v.bad_b < N && v.bresp[1]) ||
               (v.bad_r >= 0 && v.bad_r < N && v.rresp[1]) ||
               (v.dead >= 0 && v.dead < N);
    endfunction

    task automatic set_cfg(input vec_t v);
        c_aw = v.aw; c_w = v.w; c_b = v.b; c_ar = v.ar; c_r = v.r;
        c_bad_b = v.bad_b; c_bresp = v.bresp; c_bad_r = v.bad_r; c_rresp = v.rresp; c_dead = v.dead;
        clr_req++;
        tick();
        tick();
    endtask

    task automatic pulse();
        INIT_AXI_TXN = 1'b1;
        tick();
        INIT_AXI_TXN = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (TXN_DONE) begin ok = 1; break; end
        end
        chk({name, "_done"}, ok, 1);
        repeat (3) tick();
    endtask

    // Expected traffic: write i at BASE+4i with data i+1, then read the same addresses.
    task automatic check_run(input string name, input logic exp_err);
        bit wr_ok, rd_ok;
        wr_ok = (q_wa.size() == N) && (q_wd.size() == N);
        rd_ok = (q_ra.size() == N) && (rd_cnt == N);
        for (int i = 0; i < N; i++) begin
            if (wr_ok && (q_wa[i] != BASE + 32'(4 * i) || q_wd[i] != 32'(i + 1))) wr_ok = 0;
            if (rd_ok && q_ra[i] != BASE + 32'(4 * i)) rd_ok = 0;
        end
        chk({name, "_writes"}, wr_ok, 1);
        chk({name, "_reads"}, rd_ok, 1);
        chk({name, "_error"}, ERROR, exp_err);
        chk({name, "_axi_rules"}, viol, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        tbl[0] = '{0, 0, 0, 0, 0, -1, 2'b00, -1, 2'b00, -1, 1'b0};
        tbl[1] = '{3, 0, 0, 0, 0, -1, 2'b00, -1, 2'b00, -1, 1'b0};
        tbl[2] = '{0, 0, 0, 0, 0,  1, 2'b10, -1, 2'b00, -1, 1'b1};
        tbl[3] = '{0, 0, 0, 0, 0, -1, 2'b00, -1, 2'b00,  2, 1'b1};
        tbl[4] = '{1, 2, 1, 2, 1, -1, 2'b00,  3, 2'b11, -1, 1'b1};
        tbl[5] = '{1, 2, 1, 2, 1,  0, 2'b01, -1, 2'b00, -1, 1'b0};
        tbl[6] = '{0, 4, 2, 1, 3, -1, 2'b00,  0, 2'b01, -1, 1'b0};
        c_aw = 0; c_w = 0; c_b = 0; c_ar = 0; c_r = 0;
        c_bad_b = -1; c_bad_r = -1; c_dead = -1; c_bresp = 0; c_rresp = 0;

        repeat (3) tick();
        chk("rst_txn_done", TXN_DONE, 0);
        chk("rst_error", ERROR, 0);
        chk("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 0);
        chk("rst_readies", {M_AXI_BREADY, M_AXI_RREADY}, 0);
        chk("rst_addr", {M_AXI_AWADDR, M_AXI_ARADDR}, 0);
        chk("wstrb_prot", {M_AXI_WSTRB, M_AXI_AWPROT, M_AXI_ARPROT}, 64'h3C0);
        ARESETN = 1'b1;
        tick();

        // Start latency and independent AW/W completion with AWREADY 3 cycles late.
        set_cfg(tbl[1]);
        pulse();
        chk("lat_c1_awvalid", M_AXI_AWVALID, 0);
        tick();
        chk("lat_c2_awvalid", M_AXI_AWVALID, 0);
        tick();
        chk("lat_c3_aw_w_valid", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 3'b110);
        chk("lat_c3_addr", M_AXI_AWADDR, BASE);
        chk("lat_c3_data", M_AXI_WDATA, 1);
        tick();
        chk("w_drop_aw_held", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 3'b100);
        tick();
        tick();
        chk("bready_wait_aw", {M_AXI_AWVALID, M_AXI_BREADY}, 2'b10);
        tick();
        chk("bready_after_both", {M_AXI_AWVALID, M_AXI_BREADY}, 2'b01);
        wait_done("awdelay");
        check_run("awdelay", 1'b0);

        // Table of scenarios.
        for (int i = 0; i < 7; i++) begin
            set_cfg(tbl[i]);
            pulse();
            wait_done($sformatf("tbl%0d", i));
            check_run($sformatf("tbl%0d", i), tbl[i].exp_err);
            if (tbl[i].dead >= 0) begin
                chk($sformatf("tbl%0d_err_at_hs", i), err_before, 0);
                chk($sformatf("tbl%0d_err_next", i), err_after, 1);
            end
        end

        // Randomized delays and fault injection against the reference outcome.
        for (int k = 0; k < 8; k++) begin
            rv.aw = $urandom_range(0, 3); rv.w = $urandom_range(0, 3); rv.b = $urandom_range(0, 3);
            rv.ar = $urandom_range(0, 3); rv.r = $urandom_range(0, 3);
            rv.bad_b = int'($urandom_range(0, 5)) - 1; rv.bresp = 2'($urandom_range(0, 3));
            rv.bad_r = int'($urandom_range(0, 5)) - 1; rv.rresp = 2'($urandom_range(0, 3));
            rv.dead  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            rv.exp_err = model_err(rv);
            set_cfg(rv);
            pulse();
            wait_done($sformatf("rnd%0d", k));
            check_run($sformatf("rnd%0d", k), rv.exp_err);
        end

        // INIT held for 10 cycles, re-pulsed during READ: still exactly one sequence.
        set_cfg(tbl[2]);
        INIT_AXI_TXN = 1'b1;
        repeat (10) tick();
        INIT_AXI_TXN = 1'b0;
        seen = 0;
        for (int i = 0; i < 500; i++) begin
            if (M_AXI_ARVALID) begin seen = 1; break; end
            tick();
        end
        chk("held_reach_read", seen, 1);
        pulse();
        wait_done("held");
        check_run("held", 1'b1);

        // A fresh start after DONE clears both sticky flags and reruns.
        set_cfg(tbl[0]);
        pulse();
        tick();
        chk("rerun_clear", {TXN_DONE, ERROR}, 0);
        wait_done("rerun");
        check_run("rerun", 1'b0);

        // Reset while AWVALID is high.
        set_cfg(tbl[1]);
        pulse();
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (M_AXI_AWVALID) begin seen = 1; break; end
            tick();
        end
        chk("mid_awvalid_seen", seen, 1);
        #2;
        ARESETN = 1'b0;
        #1;
        chk("arst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}, 0);
        chk("arst_status", {TXN_DONE, ERROR}, 0);
        chk("arst_data", {M_AXI_AWADDR, M_AXI_WDATA}, 0);
        @(negedge ACLK);
        #1;
        ARESETN = 1'b1;
        clr_req++;
        repeat (20) tick();
        chk("post_rst_no_traffic", vld_seen, 0);
        chk("post_rst_no_hs", q_wa.size() + q_ra.size(), 0);
        chk("post_rst_done_low", TXN_DONE, 0);
        pulse();
        wait_done("after_rst");
        check_run("after_rst", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axixl_lite_txn_master.md
Name: axixl_lite_txn_master

Overview:
- AXI4-Lite master traffic generator/checker for the axixl IP's m_axi port.
- A rising edge on INIT_AXI_TXN starts a fixed sequence: N single-beat writes of an incrementing pattern, then N reads of the same addresses with data compare.
- Reports completion on TXN_DONE and any bad response or miscompare on ERROR.
- Sits between the IP's control pins and the AXI interconnect / slave VIP in the block design.

Parameters:
- C_M_TARGET_SLAVE_BASE_ADDR, 32'h4000_0000, byte address of the first register accessed.
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width; 32 or 64 only.
- C_M_TRANSACTIONS_NUM, 4, number of writes and, separately, number of reads (1..255).

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- INIT_AXI_TXN  in  1  start request; rising-edge detected.
- TXN_DONE  out  1  sequence finished; sticky until next start.
- ERROR  out  1  sticky error flag; cleared on next start.
- M_AXI_AWADDR  out  ADDR_W  write address.
- M_AXI_AWPROT  out  3  constant 3'b000.
- M_AXI_AWVALID  out  1  write address valid.
- M_AXI_AWREADY  in  1  write address ready.
- M_AXI_WDATA  out  DATA_W  write data.
- M_AXI_WSTRB  out  DATA_W/8  all ones.
- M_AXI_WVALID  out  1  write data valid.
- M_AXI_WREADY  in  1  write data ready.
- M_AXI_BRESP  in  2  write response.
- M_AXI_BVALID  in  1  write response valid.
- M_AXI_BREADY  out  1  write response ready.
- M_AXI_ARADDR  out  ADDR_W  read address.
- M_AXI_ARPROT  out  3  constant 3'b000.
- M_AXI_ARVALID  out  1  read address valid.
- M_AXI_ARREADY  in  1  read address ready.
- M_AXI_RDATA  in  DATA_W  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RVALID  in  1  read data valid.
- M_AXI_RREADY  out  1  read data ready.

Behaviour:
- Reset (async assert, sync release): every output 0. FSM = IDLE, index = 0, edge-detect flops = 0.
- Start detection:
  - INIT_AXI_TXN registered twice; start = q1 & ~q2, so INIT-to-first-AWVALID latency is 3 cycles.
  - A held-high INIT gives exactly one start.
- FSM states: IDLE, WRITE, READ, DONE.
  - IDLE: on start, clear TXN_DONE, ERROR and index, then go to WRITE. Starts in any other state are ignored.
  - WRITE: one outstanding transaction at a time.
    - Issue: assert AWVALID and WVALID in the same cycle.
      - AWADDR = base + 4*index.
      - WDATA = index+1, zero-extended.
    - Each VALID drops the cycle after its own handshake; AW and W complete independently in either order.
    - BREADY asserts once both AW and W have handshaken and drops after the B handshake.
    - On B handshake: ERROR |= BRESP[1], index++.
    - Next issue starts the cycle after the B handshake.
    - When index reaches N: index = 0, go to READ.
  - READ:
    - Issue: assert ARVALID with ARADDR = base + 4*index; hold until ARREADY.
    - After the AR handshake, assert RREADY until the R handshake.
    - On R handshake: ERROR |= RRESP[1] | (RDATA != index+1), index++.
    - When index reaches N, go to DONE.
  - DONE: assert TXN_DONE for the rest of the cycle in this state, go to IDLE. TXN_DONE stays 1 until the next start.
- Response coding: OKAY and EXOKAY are good; SLVERR and DECERR set ERROR.
- ERROR never aborts the sequence; all transactions still complete.
- Address arithmetic wraps modulo 2^ADDR_W.
- VALID, ADDR and DATA are held stable while VALID is high and READY is low (AXI rule).
- BVALID/RVALID arriving with no outstanding request are ignored (no handshake, since READY is 0).
- Reset mid-operation: all VALID/READY drop asynchronously and the sequence is abandoned. TXN_DONE stays 0 until a new start.

Decomposition:
- Shared package axixl_pkg:
  - state enum: IDLE, WRITE, READ, DONE.
  - AXI response constants: OKAY, EXOKAY, SLVERR, DECERR.
  - function for expected data (index+1).
- One sub-module, axixl_init_pulse: two-flop synchroniser plus edge detector for INIT_AXI_TXN.
- Everything else stays in one module.

Test Plan:
- Zero-wait slave with 4 registers, one INIT pulse:
  - writes go to 0x40000000/04/08/0C with data 1,2,3,4;
  - reads return the same data;
  - result: TXN_DONE=1, ERROR=0.
- AWREADY delayed 3 cycles, WREADY immediate:
  - WVALID drops after 1 cycle while AWVALID is held;
  - BREADY rises only after both handshakes;
  - never more than one transaction outstanding;
  - result: PASS.
- Slave returns SLVERR on the 2nd B:
  - all 4 writes and 4 reads still occur;
  - result: TXN_DONE=1, ERROR=1.
- Slave returns 0xDEAD for read index 2:
  - ERROR rises the cycle after that R handshake;
  - result: TXN_DONE=1.
- INIT held high 10 cycles, then a second pulse during READ:
  - exactly 4 writes and 4 reads occur;
  - a third pulse after DONE clears TXN_DONE/ERROR and reruns the sequence.
- ARESETN dropped while AWVALID=1:
  - all outputs go to 0 immediately;
  - after release there is no traffic until INIT, and TXN_DONE stays 0.
